// File: rtl/pwm_timer_ctrl.sv
// ==========================================================================
// pwm_timer_ctrl: time-base, prescaler and shadow/active register sequencer
// for one PWM channel.  Rev 1.0
// ==========================================================================
`default_nettype none

module pwm_timer_ctrl #(
  parameter int WIDTH     = 16,
  parameter int PSC_WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             one_shot,
  input  logic             preload_en,
  input  logic             wr_en,
  input  logic [1:0]       wr_sel,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] cnt,
  output logic [WIDTH-1:0] ccr,
  output logic [WIDTH-1:0] period,
  output logic             enable,
  output logic             busy,
  output logic             update_evt,
  output logic             cmp_evt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t               state;
  logic [WIDTH-1:0]     ccr_sh;
  logic [WIDTH-1:0]     per_sh;
  logic [PSC_WIDTH-1:0] psc_sh;
  logic [PSC_WIDTH-1:0] psc_act;
  logic [PSC_WIDTH-1:0] psc_cnt;

  logic                 running;
  logic                 tick;
  logic                 wrap;
  logic                 start_ok;
  logic                 load_all;
  logic                 direct;
  logic                 to_idle;
  logic                 ccr_wr;
  logic                 per_wr;
  logic                 psc_wr;
  logic                 cmp_hit;
  logic [WIDTH-1:0]     per_m1;
  logic [WIDTH-1:0]     cnt_inc;
  logic [WIDTH-1:0]     ccr_sh_nxt;
  logic [WIDTH-1:0]     per_sh_nxt;
  logic [PSC_WIDTH-1:0] psc_sh_nxt;

  assign running  = (state != IDLE);
  // >= rather than == so an immediate shrink of the prescaler cannot strand
  // the counter above the new terminal value.
  assign tick     = running && (psc_cnt >= psc_act);
  assign per_m1   = period - WIDTH'(1);
  assign wrap     = tick && ((period == '0) || (cnt >= per_m1));
  assign cnt_inc  = cnt + WIDTH'(1);
  assign start_ok = (state == IDLE) && start && !stop;
  assign load_all = wrap || start_ok;
  assign direct   = wr_en && (!preload_en || (state == IDLE));
  assign to_idle  = wrap && ((state == DRAIN) || one_shot);

  assign ccr_wr   = wr_en && (wr_sel == 2'd0);
  assign per_wr   = wr_en && (wr_sel == 2'd1);
  assign psc_wr   = wr_en && (wr_sel == 2'd2);

  // Write data bypasses into the active copy when it lands on a reload edge.
  assign ccr_sh_nxt = ccr_wr ? wr_data : ccr_sh;
  assign per_sh_nxt = per_wr ? wr_data : per_sh;
  assign psc_sh_nxt = psc_wr ? wr_data[PSC_WIDTH-1:0] : psc_sh;

  assign cmp_hit = tick && !wrap && (cnt_inc == ccr) && (ccr != '0) && (ccr < period);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      ccr        <= '0;
      period     <= '0;
      enable     <= 1'b0;
      busy       <= 1'b0;
      update_evt <= 1'b0;
      cmp_evt    <= 1'b0;
      ccr_sh     <= '0;
      per_sh     <= '0;
      psc_sh     <= '0;
      psc_act    <= '0;
      psc_cnt    <= '0;
    end else begin
      ccr_sh     <= ccr_sh_nxt;
      per_sh     <= per_sh_nxt;
      psc_sh     <= psc_sh_nxt;
      update_evt <= wrap;
      cmp_evt    <= cmp_hit;

      if (load_all) begin
        ccr     <= ccr_sh_nxt;
        period  <= per_sh_nxt;
        psc_act <= psc_sh_nxt;
      end else if (direct) begin
        if (ccr_wr) ccr     <= wr_data;
        if (per_wr) period  <= wr_data;
        if (psc_wr) psc_act <= wr_data[PSC_WIDTH-1:0];
      end

      case (state)
        IDLE: begin
          if (start_ok) begin
            state   <= RUN;
            enable  <= 1'b1;
            busy    <= 1'b1;
            cnt     <= '0;
            psc_cnt <= '0;
          end
        end
        RUN, DRAIN: begin
          if (to_idle) begin
            state   <= IDLE;
            enable  <= 1'b0;
            busy    <= 1'b0;
            cnt     <= '0;
            psc_cnt <= '0;
          end else begin
            if ((state == RUN) && stop) state <= DRAIN;
            if (tick) begin
              psc_cnt <= '0;
              cnt     <= wrap ? '0 : cnt_inc;
            end else begin
              psc_cnt <= psc_cnt + PSC_WIDTH'(1);
            end
          end
        end
        default: begin
          state   <= IDLE;
          enable  <= 1'b0;
          busy    <= 1'b0;
          cnt     <= '0;
          psc_cnt <= '0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pwm_timer_ctrl.sv
// ==========================================================================
// tb_pwm_timer_ctrl: directed vector table plus hand-written multi-cycle
// sequences for pwm_timer_ctrl.  Rev 1.0
// ==========================================================================
`default_nettype none

module tb_pwm_timer_ctrl;

  localparam int WIDTH     = 16;
  localparam int PSC_WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             one_shot = 1'b0;
  logic             preload_en = 1'b0;
  logic             wr_en = 1'b0;
  logic [1:0]       wr_sel = 2'd0;
  logic [WIDTH-1:0] wr_data = '0;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] ccr;
  logic [WIDTH-1:0] period;
  logic             enable;
  logic             busy;
  logic             update_evt;
  logic             cmp_evt;

  int checks = 0;
  int errors = 0;

  pwm_timer_ctrl #(.WIDTH(WIDTH), .PSC_WIDTH(PSC_WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .one_shot   (one_shot),
    .preload_en (preload_en),
    .wr_en      (wr_en),
    .wr_sel     (wr_sel),
    .wr_data    (wr_data),
    .cnt        (cnt),
    .ccr        (ccr),
    .period     (period),
    .enable     (enable),
    .busy       (busy),
    .update_evt (update_evt),
    .cmp_evt    (cmp_evt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        start;
    logic        stop;
    logic        wr_en;
    logic [1:0]  wr_sel;
    logic [15:0] wr_data;
    logic [15:0] e_cnt;
    logic [15:0] e_ccr;
    logic [15:0] e_per;
    logic        e_en;
    logic        e_upd;
    logic        e_cmp;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] sel, input logic [15:0] d);
    wr_en = 1'b1; wr_sel = sel; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic wait_cnt(input logic [15:0] v, input int max, input string name);
    int n = 0;
    while (cnt !== v && n < max) begin
      step();
      n++;
    end
    chk(name, cnt, v);
  endtask

  task automatic wait_idle(input int max, input string name);
    int n = 0;
    while (busy !== 1'b0 && n < max) begin
      step();
      n++;
    end
    chk(name, busy, 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".cnt"}, cnt, 0);
    chk({tag, ".ccr"}, ccr, 0);
    chk({tag, ".period"}, period, 0);
    chk({tag, ".enable"}, enable, 0);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".update_evt"}, update_evt, 0);
    chk({tag, ".cmp_evt"}, cmp_evt, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_upd;
    int n_cmp;
    int seq [9];

    // Basic run: CCR=3, PERIOD=8, PSC=0 programmed in IDLE, then START.
    //              st st we sel  data   cnt ccr per en upd cmp
    tbl[0]  = '{1'b0,1'b0,1'b1,2'd0,16'd3, 16'd0,16'd3,16'd0,1'b0,1'b0,1'b0};
    tbl[1]  = '{1'b0,1'b0,1'b1,2'd1,16'd8, 16'd0,16'd3,16'd8,1'b0,1'b0,1'b0};
    tbl[2]  = '{1'b0,1'b0,1'b1,2'd2,16'd0, 16'd0,16'd3,16'd8,1'b0,1'b0,1'b0};
    tbl[3]  = '{1'b1,1'b0,1'b0,2'd0,16'd0, 16'd0,16'd3,16'd8,1'b1,1'b0,1'b0};
    tbl[4]  = '{1'b0,1'b0,1'b0,2'd0,16'd0, 16'd1,16'd3,16'd8,1'b1,1'b0,1'b0};
    tbl[5]  = '{1'b0,1'b0,1'b0,2'd0,16'd0, 16'd2,16'd3,16'd8,1'b1,1'b0,1'b0};
    tbl[6]  = '{1'b0,1'b0,1'b0,2'd0,16'd0, 16'd3,16'd3,16'd8,1'b1,1'b0,1'b1};
    tbl[7]  = '{1'b0,1'b0,1'b0,2'd0,16'd0, 16'd4,16'd3,16'd8,1'b1,1'b0,1'b0};
    tbl[8]  = '{1'b0,1'b0,1'b0,2'd0,16'd0, 16'd5,16'd3,16'd8,1'b1,1'b0,1'b0};
    tbl[9]  = '{1'b0,1'b0,1'b0,2'd0,16'd0, 16'd6,16'd3,16'd8,1'b1,1'b0,1'b0};
    tbl[10] = '{1'b0,1'b0,1'b0,2'd0,16'd0, 16'd7,16'd3,16'd8,1'b1,1'b0,1'b0};
    tbl[11] = '{1'b0,1'b0,1'b0,2'd0,16'd0, 16'd0,16'd3,16'd8,1'b1,1'b1,1'b0};
    tbl[12] = '{1'b0,1'b0,1'b0,2'd0,16'd0, 16'd1,16'd3,16'd8,1'b1,1'b0,1'b0};
    tbl[13] = '{1'b0,1'b0,1'b0,2'd0,16'd0, 16'd2,16'd3,16'd8,1'b1,1'b0,1'b0};
    tbl[14] = '{1'b0,1'b0,1'b0,2'd0,16'd0, 16'd3,16'd3,16'd8,1'b1,1'b0,1'b1};

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 15; i++) begin
      start = tbl[i].start; stop = tbl[i].stop;
      wr_en = tbl[i].wr_en; wr_sel = tbl[i].wr_sel; wr_data = tbl[i].wr_data;
      step();
      start = 1'b0; stop = 1'b0; wr_en = 1'b0;
      chk($sformatf("vec%0d.cnt", i), cnt, tbl[i].e_cnt);
      chk($sformatf("vec%0d.ccr", i), ccr, tbl[i].e_ccr);
      chk($sformatf("vec%0d.period", i), period, tbl[i].e_per);
      chk($sformatf("vec%0d.enable", i), enable, tbl[i].e_en);
      chk($sformatf("vec%0d.busy", i), busy, tbl[i].e_en);
      chk($sformatf("vec%0d.update_evt", i), update_evt, tbl[i].e_upd);
      chk($sformatf("vec%0d.cmp_evt", i), cmp_evt, tbl[i].e_cmp);
    end

    // STOP at CNT=5 drains to the end of the period.
    wait_cnt(16'd5, 20, "stop.reach5");
    do_stop();
    chk("stop.cnt6", cnt, 6);
    chk("stop.busy6", busy, 1);
    step();
    chk("stop.cnt7", cnt, 7);
    chk("stop.en7", enable, 1);
    step();
    chk("stop.wrap_cnt", cnt, 0);
    chk("stop.wrap_upd", update_evt, 1);
    chk("stop.wrap_en", enable, 0);
    chk("stop.wrap_busy", busy, 0);
    step();
    chk("stop.after_upd", update_evt, 0);
    chk("stop.after_cnt", cnt, 0);

    // Preloaded PERIOD change takes effect only at rollover.
    preload_en = 1'b1;
    do_start();
    chk("pre.start_en", enable, 1);
    wait_cnt(16'd2, 20, "pre.reach2");
    wr(2'd1, 16'd4);
    chk("pre.wr_cnt", cnt, 3);
    chk("pre.wr_per", period, 8);
    chk("pre.wr_cmp", cmp_evt, 1);
    seq = '{4, 5, 6, 7, 0, 1, 2, 3, 0};
    for (int i = 0; i < 9; i++) begin
      step();
      chk($sformatf("pre%0d.cnt", i), cnt, seq[i]);
      chk($sformatf("pre%0d.period", i), period, (i < 4) ? 8 : 4);
      chk($sformatf("pre%0d.upd", i), update_evt, (seq[i] == 0) ? 1 : 0);
      chk($sformatf("pre%0d.cmp", i), cmp_evt, (seq[i] == 3) ? 1 : 0);
    end

    // Immediate PERIOD change: CNT=5 with PERIOD=4 rolls on the next tick.
    preload_en = 1'b0;
    wr(2'd1, 16'd8);
    chk("imm.per8", period, 8);
    wait_cnt(16'd4, 20, "imm.reach4");
    wr(2'd1, 16'd4);
    chk("imm.cnt5", cnt, 5);
    chk("imm.per4", period, 4);
    step();
    chk("imm.wrap_cnt", cnt, 0);
    chk("imm.wrap_upd", update_evt, 1);
    do_stop();
    wait_idle(20, "imm.idle");

    // Prescaler 2, PERIOD 4: one count per 3 cycles, rollover every 12.
    wr(2'd2, 16'd2);
    wr(2'd1, 16'd4);
    wr(2'd0, 16'd0);
    do_start();
    chk("psc.start_cnt", cnt, 0);
    for (int k = 1; k <= 24; k++) begin
      step();
      chk($sformatf("psc%0d.cnt", k), cnt, (k / 3) % 4);
      chk($sformatf("psc%0d.upd", k), update_evt, (k % 12 == 0) ? 1 : 0);
    end
    do_stop();
    wait_idle(40, "psc.idle");

    // One-shot sweep over PERIOD=5 with CCR=2.
    wr(2'd2, 16'd0);
    wr(2'd1, 16'd5);
    wr(2'd0, 16'd2);
    one_shot = 1'b1;
    do_start();
    chk("os.start_en", enable, 1);
    chk("os.start_cnt", cnt, 0);
    n_upd = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (update_evt) n_upd++;
      chk($sformatf("os%0d.cnt", i), cnt, (i + 1) % 5);
      chk($sformatf("os%0d.en", i), enable, (i < 4) ? 1 : 0);
      chk($sformatf("os%0d.cmp", i), cmp_evt, (i == 1) ? 1 : 0);
    end
    repeat (3) begin
      step();
      if (update_evt) n_upd++;
    end
    chk("os.upd_count", n_upd, 1);
    chk("os.final_cnt", cnt, 0);
    chk("os.final_en", enable, 0);
    one_shot = 1'b0;

    // START and STOP together from IDLE: stay idle.
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    chk("ss.en", enable, 0);
    chk("ss.busy", busy, 0);
    step();
    chk("ss.en2", enable, 0);
    chk("ss.cnt2", cnt, 0);

    // Asynchronous reset mid-period, then restart with all-zero shadows.
    wr(2'd1, 16'd8);
    do_start();
    wait_cnt(16'd6, 20, "rst.reach6");
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("rst.mid");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    do_start();
    chk("rst.restart_en", enable, 1);
    chk("rst.restart_per", period, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("p0_%0d.cnt", i), cnt, 0);
      chk($sformatf("p0_%0d.upd", i), update_evt, 1);
    end
    do_stop();
    wait_idle(10, "p0.idle");

    // CCR=0 and CCR>=PERIOD never raise CMP_EVT.
    for (int c = 0; c < 2; c++) begin
      wr(2'd0, (c == 0) ? 16'd0 : 16'd10);
      wr(2'd1, 16'd8);
      do_start();
      n_upd = 0;
      n_cmp = 0;
      repeat (24) begin
        step();
        if (update_evt) n_upd++;
        if (cmp_evt) n_cmp++;
      end
      chk($sformatf("nocmp%0d.cmp_count", c), n_cmp, 0);
      chk($sformatf("nocmp%0d.upd_count", c), n_upd, 3);
      do_stop();
      wait_idle(20, $sformatf("nocmp%0d.idle", c));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
